// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared widths, types and arithmetic helpers for the Sobel edge stream
package sobel_pkg;

  localparam int PIX_W   = 8;
  localparam int GRAD_W  = 11;
  localparam int MAG_W   = 11;
  localparam int LATENCY = 3;

  typedef logic [PIX_W-1:0]         pixel_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  // win[r][c]: row 0 is two lines up, row 2 is the current line; col 2 is newest
  typedef pixel_t [0:2][0:2]        window_t;

  // Zero-extend a pixel into the signed gradient domain
  function automatic grad_t ext(input pixel_t p);
    return grad_t'({3'b000, p});
  endfunction

  // |g| fits in 10 bits because gradients are bounded to +/-1020
  function automatic logic [9:0] abs_grad(input grad_t g);
    return 10'(g[GRAD_W-1] ? -g : g);
  endfunction

endpackage

// File: rtl/sobel_edge_stream_if.sv
// rtl/sobel_edge_stream_if.sv - raster pixel input and edge pixel output bundle
interface sobel_edge_stream_if;
  import sobel_pkg::*;

  pixel_t pixel_in;
  logic   valid_in;
  logic   frame_start;
  pixel_t edge_out;
  logic   edge_valid;

  modport master (
    output pixel_in, valid_in, frame_start,
    input  edge_out, edge_valid
  );

  modport slave (
    input  pixel_in, valid_in, frame_start,
    output edge_out, edge_valid
  );

endinterface

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - one line of pixels, single port, read-before-write
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int WIDTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pixel_t        wdata,
  output pixel_t        rdata
);

  pixel_t mem [WIDTH];

  // Asynchronous read returns the old contents on the same edge that overwrites them
  assign rdata = mem[addr];

  // Write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_edge_stream.sv
// rtl/sobel_edge_stream.sv - 3x3 Sobel magnitude on a raster stream; SOBEL_THRESHOLD_EN selects binarised output
module sobel_edge_stream
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int THRESH = 64
) (
  input  logic               clk,
  input  logic               reset,
  sobel_edge_stream_if.slave s
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  if (WIDTH < 3 || HEIGHT < 3 || THRESH < 0) begin : g_bad_cfg
    $error("sobel_edge_stream: unsupported WIDTH/HEIGHT/THRESH");
  end

  logic [COL_W-1:0] col, ec;
  logic [ROW_W-1:0] row, er;
  pixel_t           lb0_rd, lb1_rd;
  window_t          win;
  logic             v1, zf1, v2, zf2, v3;
  logic [9:0]       ax2, ay2;
  grad_t            gx, gy;
  logic [MAG_W-1:0] mag;
  pixel_t           res;
  pixel_t           edge_q;

  // frame_start forces this cycle's pixel to (0,0)
  assign ec = s.frame_start ? '0 : col;
  assign er = s.frame_start ? '0 : row;

  // lb1 holds the previous line, lb0 the one before; lb0 is refilled from lb1
  sobel_line_buffer #(.WIDTH(WIDTH), .AW(COL_W)) u_lb1 (
    .clk(clk), .we(s.valid_in), .addr(ec), .wdata(s.pixel_in), .rdata(lb1_rd)
  );
  sobel_line_buffer #(.WIDTH(WIDTH), .AW(COL_W)) u_lb0 (
    .clk(clk), .we(s.valid_in), .addr(ec), .wdata(lb1_rd), .rdata(lb0_rd)
  );

  // Raster position of the next accepted pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (s.valid_in) begin
      if (ec == COL_W'(WIDTH - 1)) begin
        col <= '0;
        row <= (er == ROW_W'(HEIGHT - 1)) ? '0 : er + 1'b1;
      end else begin
        col <= ec + 1'b1;
        row <= er;
      end
    end else if (s.frame_start) begin
      col <= '0;
      row <= '0;
    end
  end

  // Stage 1: shift the window on accepted pixels and tag border outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win <= '0;
      v1  <= 1'b0;
      zf1 <= 1'b0;
    end else begin
      v1 <= s.valid_in;
      if (s.valid_in) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb0_rd;
        win[1][2] <= lb1_rd;
        win[2][2] <= s.pixel_in;
        zf1       <= (er < ROW_W'(2)) || (ec < COL_W'(2));
      end
    end
  end

  assign gx = (ext(win[0][2]) + ext(win[1][2]) + ext(win[1][2]) + ext(win[2][2]))
            - (ext(win[0][0]) + ext(win[1][0]) + ext(win[1][0]) + ext(win[2][0]));
  assign gy = (ext(win[2][0]) + ext(win[2][1]) + ext(win[2][1]) + ext(win[2][2]))
            - (ext(win[0][0]) + ext(win[0][1]) + ext(win[0][1]) + ext(win[0][2]));

  // Stage 2: register gradient magnitudes per axis
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2  <= 1'b0;
      zf2 <= 1'b0;
      ax2 <= '0;
      ay2 <= '0;
    end else begin
      v2  <= v1;
      zf2 <= zf1;
      ax2 <= abs_grad(gx);
      ay2 <= abs_grad(gy);
    end
  end

  assign mag = {1'b0, ax2} + {1'b0, ay2};

`ifdef SOBEL_THRESHOLD_EN
  assign res = (mag >= MAG_W'(THRESH)) ? 8'd255 : 8'd0;
`else
  assign res = (|mag[MAG_W-1:PIX_W]) ? 8'd255 : mag[PIX_W-1:0];
`endif

  // Stage 3: border masking and output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v3     <= 1'b0;
      edge_q <= '0;
    end else begin
      v3     <= v2;
      edge_q <= zf2 ? 8'd0 : res;
    end
  end

  assign s.edge_out   = edge_q;
  assign s.edge_valid = v3;

endmodule

// File: tb/tb_sobel_edge_stream.sv
// tb/tb_sobel_edge_stream.sv - directed self-checking bench for sobel_edge_stream
module tb_sobel_edge_stream;

  localparam int W = 8;
  localparam int H = 6;
  localparam int K_FLAT = 0, K_STEP = 1, K_RAMP = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sobel_edge_stream_if sif ();
  sobel_edge_stream_if sif96 ();
  assign sif96.pixel_in    = sif.pixel_in;
  assign sif96.valid_in    = sif.valid_in;
  assign sif96.frame_start = sif.frame_start;

  sobel_edge_stream #(.WIDTH(W), .HEIGHT(H), .THRESH(64)) dut (
    .clk(clk), .reset(reset), .s(sif)
  );
  sobel_edge_stream #(.WIDTH(W), .HEIGHT(H), .THRESH(96)) dut96 (
    .clk(clk), .reset(reset), .s(sif96)
  );

  int checks = 0;
  int errors = 0;
  int pcnt = 0;
  int in_q[$], cyc_q[$], out_q[$], cyc96_q[$], out96_q[$], e64_q[$], e96_q[$];

  always @(posedge clk) pcnt <= pcnt + 1;

  always @(negedge clk) begin
    if (sif.edge_valid) begin
      cyc_q.push_back(pcnt);
      out_q.push_back(int'(sif.edge_out));
    end
    if (sif96.edge_valid) begin
      cyc96_q.push_back(pcnt);
      out96_q.push_back(int'(sif96.edge_out));
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int inp(input int kind, input int c);
    if (kind == K_FLAT) return 100;
    if (kind == K_STEP) return (c >= 4) ? 200 : 0;
    return 10 * c;
  endfunction

  // Hand-derived saturated magnitudes for the window centred at (r-1,c-1)
  function automatic int hand(input int kind, input int r, input int c);
    if (r < 2 || c < 2) return 0;
    if (kind == K_STEP) return (c == 4 || c == 5) ? 255 : 0;
    if (kind == K_RAMP) return 80;
    return 0;
  endfunction

  function automatic int thr(input int v, input int t);
`ifdef SOBEL_THRESHOLD_EN
    if (v == 0) return 0;
    return (v >= t) ? 255 : 0;
`else
    if (t < 0) return -1;
    return v;
`endif
  endfunction

  task automatic send(input int p, input bit v, input bit fs);
    @(negedge clk);
    sif.pixel_in    = 8'(p);
    sif.valid_in    = v;
    sif.frame_start = fs;
    if (v) in_q.push_back(pcnt + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) send(8'h5A, 1'b0, 1'b0);
  endtask

  task automatic frame(input int kind, input bit toggle, input bit fs_first, input int npix);
    for (int i = 0; i < npix; i++) begin
      int r, c, e;
      r = (i / W) % H;
      c = i % W;
      e = hand(kind, r, c);
      send(inp(kind, c), 1'b1, fs_first && (i == 0));
      e64_q.push_back(thr(e, 64));
      e96_q.push_back(thr(e, 96));
      if (toggle) send(8'hAA, 1'b0, 1'b0);
    end
  endtask

  task automatic clear_all();
    in_q.delete(); cyc_q.delete(); out_q.delete();
    cyc96_q.delete(); out96_q.delete(); e64_q.delete(); e96_q.delete();
  endtask

  task automatic check_frame(input string tag);
    idle(5);
    chk($sformatf("%s.count", tag), out_q.size(), e64_q.size());
    chk($sformatf("%s.count96", tag), out96_q.size(), e96_q.size());
    for (int i = 0; i < e64_q.size(); i++) begin
      if (i < out_q.size()) begin
        chk($sformatf("%s.out[%0d]", tag, i), out_q[i], e64_q[i]);
        chk($sformatf("%s.lat[%0d]", tag, i), cyc_q[i], in_q[i] + 2);
      end
      if (i < out96_q.size()) begin
        chk($sformatf("%s.out96[%0d]", tag, i), out96_q[i], e96_q[i]);
        chk($sformatf("%s.lat96[%0d]", tag, i), cyc96_q[i], in_q[i] + 2);
      end
    end
    clear_all();
  endtask

  initial begin
    sif.pixel_in    = '0;
    sif.valid_in    = 1'b0;
    sif.frame_start = 1'b0;
    reset           = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.edge_valid", int'(sif.edge_valid), 0);
    chk("rst.edge_out", int'(sif.edge_out), 0);
    reset = 1'b0;

    frame(K_STEP, 1'b0, 1'b0, 20);
    @(negedge clk);
    sif.valid_in = 1'b0;
    chk("pre_rst.edge_valid", int'(sif.edge_valid), 1);
    reset = 1'b1;
    #1;
    chk("async_rst.edge_valid", int'(sif.edge_valid), 0);
    chk("async_rst.edge_out", int'(sif.edge_out), 0);
    chk("async_rst.edge_valid96", int'(sif96.edge_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    clear_all();

    frame(K_STEP, 1'b0, 1'b0, W * H);
    check_frame("step");
    frame(K_FLAT, 1'b0, 1'b0, W * H);
    check_frame("flat");
    frame(K_RAMP, 1'b0, 1'b0, W * H);
    check_frame("ramp");
    frame(K_RAMP, 1'b1, 1'b0, W * H);
    check_frame("ramp_gap");

    frame(K_RAMP, 1'b0, 1'b0, 13);
    frame(K_RAMP, 1'b0, 1'b1, W * H);
    check_frame("fs_valid");

    frame(K_RAMP, 1'b0, 1'b0, 5);
    send(8'h33, 1'b0, 1'b1);
    frame(K_RAMP, 1'b0, 1'b0, W * H);
    check_frame("fs_alone");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_edge_stream.md
Name: sobel_edge_stream

Overview:
- Downstream consumer of the grayscale producer's pixel_out/valid raster stream.
- Computes a 3x3 Sobel gradient magnitude per accepted pixel, using two internal line buffers.
- Emits one 8-bit edge pixel per input pixel with fixed latency, for the display/threshold stages that follow.
- No backpressure: the source never stalls; bubbles (valid low) pass through the pipeline.

Parameters:
WIDTH, 640, pixels per row; line buffer depth
HEIGHT, 480, rows per frame
THRESH, 64, binarisation threshold (used only with SOBEL_THRESHOLD_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pixel_in  input  8  grayscale pixel from producer
valid_in  input  1  pixel_in is valid this cycle
frame_start  input  1  next accepted pixel is (row 0, col 0)
edge_out  output  8  gradient magnitude, saturated
edge_valid  output  1  edge_out is valid this cycle

Behaviour:
- Reset (async, active-high): col=0, row=0, window regs=0, all stage valids=0, edge_out=0, edge_valid=0. Line buffer RAM is not cleared.
- Position counters:
  - col/row advance only on valid_in; col wraps at WIDTH-1 -> 0 with row++; row wraps at HEIGHT-1 -> 0.
  - frame_start has priority. frame_start & valid_in: pixel is (0,0), then col=1. frame_start alone: col=row=0 for the next pixel.
- Stage 1 (edge accepting the pixel):
  - read lb1[col] (row-1) and lb0[col] (row-2);
  - write lb0[col]<=lb1[col], lb1[col]<=pixel_in (read-before-write);
  - shift the 3x3 window left one column, new column {lb0, lb1, pixel_in};
  - tag zero_flag = (row<2)||(col<2).
- Stage 2 (every clock): Gx = (p02+2p12+p22)-(p00+2p10+p20); Gy = (p20+2p21+p22)-(p00+2p01+p02); both 11-bit signed, range ±1020. Register |Gx| and |Gy| as 10-bit values.
- Stage 3 (every clock): mag = |Gx|+|Gy| (11-bit, max 2040); edge_out = zero_flag ? 0 : min(mag,255).
- Latency: input accepted on edge N -> edge_valid=1 on the cycle after edge N+2 (3 register stages). edge_valid is valid_in delayed by exactly 3 edges, including gaps.
- Spatial offset: the output for input (r,c) is the window centred at (r-1,c-1). Every frame yields exactly WIDTH*HEIGHT outputs; the first two rows and first two columns of outputs are 0.
- Stale line-buffer data (after reset or frame_start) is never visible, because zero_flag masks it.
- Reset mid-frame: counters restart at (0,0); the pipeline is flushed; no edge_valid until 3 edges after the next valid_in.
- Valid-low cycles leave counters, window and RAM untouched; stages 2/3 still clock and carry valid=0.

Optional Feature:
- SOBEL_THRESHOLD_EN defined: edge_out = zero_flag ? 0 : (mag >= THRESH ? 8'd255 : 8'd0). Latency is unchanged.
- Undefined: saturated magnitude as above; THRESH is ignored.

Decomposition:
- Package sobel_pkg:
  - PIX_W=8, GRAD_W=11, MAG_W=11;
  - typedef pixel_t (logic[7:0]), grad_t (signed [10:0]);
  - typedef window_t (3x3 pixel_t array);
  - LATENCY=3.
- Sub-module sobel_line_buffer: WIDTH x 8 single-port RAM with read-before-write, one instance each for lb0 and lb1. Counters, window and arithmetic stay in the top module.

Test Plan (bench uses WIDTH=8, HEIGHT=6):
- Reset: hold reset 3 cycles, then assert it again mid-frame after 20 pixels. Required: edge_out=0 and edge_valid=0 immediately (async); the next frame restarts at (0,0).
- Flat frame, all pixels 100, valid continuous. Required: exactly 48 edge_valid pulses, each 3 edges after its input, all edge_out=0.
- Vertical step, cols 0-3=0 and cols 4-7=200. Required: edge_out=255 (mag 800 saturated) at input cols 4 and 5 for rows 2-5; all other outputs 0.
- Horizontal ramp, pixel=10*col. Required: edge_out=80 for input cols 2-7 in rows 2-5 (Gx=80, Gy=0); all other outputs 0.
- Ramp frame again with valid_in toggling every other cycle. Required: same 48 values in the same order; edge_valid pattern equals valid_in shifted by 3.
- frame_start pulsed after 13 pixels, then SOBEL_THRESHOLD_EN ramp runs:
  - after frame_start, the next 16 outputs are 0 and counters restart;
  - with THRESH=64, interior outputs are 255; with THRESH=96, all outputs are 0.
